// File: rtl/ysyx_22040759_bru_bp_pkg.sv
// Shared definitions for the branch resolution unit and its predictor table:
// bru_sel operation codes, the write-back select that marks a link write,
// the 2-bit counter type with its reset value, and small decode helpers.
package ysyx_22040759_bru_bp_pkg;

    localparam int unsigned BRU_SEL_W  = 5;
    localparam int unsigned WREG_SEL_W = 2;
    localparam int unsigned CNT_W      = 2;

    localparam logic [BRU_SEL_W-1:0] bru_jal  = 5'd1;
    localparam logic [BRU_SEL_W-1:0] bru_jalr = 5'd2;
    localparam logic [BRU_SEL_W-1:0] bru_beq  = 5'd3;
    localparam logic [BRU_SEL_W-1:0] bru_bne  = 5'd4;
    localparam logic [BRU_SEL_W-1:0] bru_blt  = 5'd5;
    localparam logic [BRU_SEL_W-1:0] bru_bge  = 5'd6;
    localparam logic [BRU_SEL_W-1:0] bru_bltu = 5'd7;
    localparam logic [BRU_SEL_W-1:0] bru_bgeu = 5'd8;

    localparam logic [WREG_SEL_W-1:0] wreg_pc = 2'd2;

    typedef logic [CNT_W-1:0] bp_cnt_t;

    localparam bp_cnt_t bp_cnt_init = 2'b01;

    // Saturating step of a 2-bit counter toward taken (up) or not taken (down).
    function automatic bp_cnt_t bp_cnt_step(input bp_cnt_t cnt, input logic taken);
        bp_cnt_t res;
        res = cnt;
        if (taken) begin
            if (cnt != 2'b11) res = cnt + 2'b01;
        end else begin
            if (cnt != 2'b00) res = cnt - 2'b01;
        end
        return res;
    endfunction

endpackage

// File: rtl/ysyx_22040759_bp_table.sv
// Direct-mapped predictor table: 2-bit counter, valid, tag and target per
// entry. Combinational lookup for IF (reads pre-write state), update on the
// clock edge that ends a resolve cycle. Counters/valids reset; tags and
// targets do not, since they are only consulted behind valid.
module ysyx_22040759_bp_table
    import ysyx_22040759_bru_bp_pkg::*;
#(
    parameter int unsigned XLEN      = 64,
    parameter int unsigned BHT_DEPTH = 64,
    parameter int unsigned TAG_W     = 8
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [XLEN-1:0]              rd_pc,
    output logic                         rd_taken_c,
    output logic [XLEN-1:0]              rd_next_pc_c,
    input  logic                         upd_en,
    input  logic [$clog2(BHT_DEPTH)-1:0] upd_idx,
    input  logic [TAG_W-1:0]             upd_tag,
    input  logic                         upd_taken,
    input  logic [XLEN-1:0]              upd_target
);

    localparam int unsigned IDX_W = $clog2(BHT_DEPTH);

    bp_cnt_t           cnt_q    [BHT_DEPTH];
    bp_cnt_t           cnt_d    [BHT_DEPTH];
    logic              valid_q  [BHT_DEPTH];
    logic              valid_d  [BHT_DEPTH];
    logic [TAG_W-1:0]  tag_q    [BHT_DEPTH];
    logic [TAG_W-1:0]  tag_d    [BHT_DEPTH];
    logic [XLEN-1:0]   target_q [BHT_DEPTH];
    logic [XLEN-1:0]   target_d [BHT_DEPTH];

    logic [IDX_W-1:0]  rd_idx;
    logic [TAG_W-1:0]  rd_tag;
    logic              rd_hit;
    logic              upd_hit;
    bp_cnt_t           upd_base;

    // Lookup for IF: hit needs a valid entry with matching tag.
    always_comb begin
        rd_idx       = rd_pc[IDX_W+1:2];
        rd_tag       = rd_pc[IDX_W+TAG_W+1:IDX_W+2];
        rd_hit       = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
        rd_taken_c   = rd_hit && cnt_q[rd_idx][1];
        rd_next_pc_c = rd_taken_c ? target_q[rd_idx] : rd_pc + XLEN'(4);
    end

    // Next table state: a foreign or empty entry restarts from the init count.
    always_comb begin
        cnt_d    = cnt_q;
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        upd_hit  = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
        upd_base = upd_hit ? cnt_q[upd_idx] : bp_cnt_init;
        if (upd_en) begin
            cnt_d[upd_idx] = bp_cnt_step(upd_base, upd_taken);
            if (upd_taken) begin
                valid_d[upd_idx]  = 1'b1;
                tag_d[upd_idx]    = upd_tag;
                target_d[upd_idx] = upd_target;
            end
        end
    end

    // Counter and valid state, reset to weakly-not-taken / empty.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q   <= '{default: bp_cnt_init};
            valid_q <= '{default: 1'b0};
        end else begin
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

    // Tag and target payload; held during reset, only meaningful when valid.
    always_ff @(posedge clock) begin
        if (!reset) begin
            tag_q    <= tag_d;
            target_q <= target_d;
        end
    end

endmodule

// File: rtl/ysyx_22040759_bru_bp.sv
// EX-stage branch resolution with integrated predictor. Resolves JAL/JALR and
// B-type outcomes, compares against the prediction carried from IF, and
// raises a registered one-cycle redirect on mispredict. The cycle carrying
// that redirect is wrong-path, so EX input is ignored in it.
// Optional build macro YSYX_22040759_BP_STATS_EN adds resolve/mispredict counters.
module ysyx_22040759_bru_bp
    import ysyx_22040759_bru_bp_pkg::*;
#(
    parameter int unsigned XLEN      = 64,
    parameter int unsigned BHT_DEPTH = 64,
    parameter int unsigned TAG_W     = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [XLEN-1:0]       if_pc,
    output logic                  if_pred_taken,
    output logic [XLEN-1:0]       if_pred_pc,
    input  logic                  ex_valid,
    input  logic [XLEN-1:0]       src1,
    input  logic [XLEN-1:0]       src2,
    input  logic [BRU_SEL_W-1:0]  bru_sel,
    input  logic [WREG_SEL_W-1:0] bru_wreg_sel,
    input  logic [XLEN-1:0]       imme_b,
    input  logic [XLEN-1:0]       pc_out,
    input  logic                  ex_pred_taken,
    input  logic [XLEN-1:0]       ex_pred_pc,
    output logic                  br_taken,
    output logic [XLEN-1:0]       bru_pc,
    output logic                  flush_valid,
    output logic [XLEN-1:0]       flush_pc
`ifdef YSYX_22040759_BP_STATS_EN
    ,
    output logic [63:0]           stat_br_cnt,
    output logic [63:0]           stat_mis_cnt
`endif
);

    localparam int unsigned IDX_W = $clog2(BHT_DEPTH);

    logic            equ;
    logic            lt;
    logic            ltu;
    logic            is_br;
    logic            taken_raw;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] actual_next;
    logic            resolve;
    logic            mispredict;

    logic            flush_valid_q, flush_valid_d;
    logic [XLEN-1:0] flush_pc_q, flush_pc_d;

    assign equ = (src1 == src2);
    assign lt  = ($signed(src1) < $signed(src2));
    assign ltu = (src1 < src2);

    // Decode the operation into a raw outcome and target.
    always_comb begin
        is_br     = 1'b1;
        taken_raw = 1'b0;
        target    = pc_out + imme_b;
        case (bru_sel)
            bru_jal:  taken_raw = (bru_wreg_sel == wreg_pc);
            bru_jalr: begin
                taken_raw = (bru_wreg_sel == wreg_pc);
                target    = (src1 + imme_b) & ~XLEN'(1);
            end
            bru_beq:  taken_raw = equ;
            bru_bne:  taken_raw = !equ;
            bru_blt:  taken_raw = lt;
            bru_bge:  taken_raw = !lt;
            bru_bltu: taken_raw = ltu;
            bru_bgeu: taken_raw = !ltu;
            default:  is_br     = 1'b0;
        endcase
    end

    // Resolve, compare against the carried prediction, form the redirect.
    always_comb begin
        resolve       = ex_valid && is_br && !flush_valid_q;
        actual_next   = taken_raw ? target : pc_out + XLEN'(4);
        mispredict    = (taken_raw != ex_pred_taken) ||
                        (taken_raw && (ex_pred_pc != target));
        flush_valid_d = resolve && mispredict;
        flush_pc_d    = flush_valid_d ? actual_next : flush_pc_q;
    end

    // Redirect register; reset wins over any same-cycle mispredict.
    always_ff @(posedge clock) begin
        if (reset) begin
            flush_valid_q <= 1'b0;
            flush_pc_q    <= '0;
        end else begin
            flush_valid_q <= flush_valid_d;
            flush_pc_q    <= flush_pc_d;
        end
    end

    assign br_taken    = resolve && taken_raw;
    assign bru_pc      = target;
    assign flush_valid = flush_valid_q;
    assign flush_pc    = flush_pc_q;

    ysyx_22040759_bp_table #(
        .XLEN      (XLEN),
        .BHT_DEPTH (BHT_DEPTH),
        .TAG_W     (TAG_W)
    ) u_table (
        .clock        (clock),
        .reset        (reset),
        .rd_pc        (if_pc),
        .rd_taken_c   (if_pred_taken),
        .rd_next_pc_c (if_pred_pc),
        .upd_en       (resolve),
        .upd_idx      (pc_out[IDX_W+1:2]),
        .upd_tag      (pc_out[IDX_W+TAG_W+1:IDX_W+2]),
        .upd_taken    (taken_raw),
        .upd_target   (target)
    );

`ifdef YSYX_22040759_BP_STATS_EN
    logic [63:0] stat_br_cnt_q, stat_br_cnt_d;
    logic [63:0] stat_mis_cnt_q, stat_mis_cnt_d;

    // Resolve and mispredict tallies, wrapping naturally at 2^64.
    always_comb begin
        stat_br_cnt_d  = stat_br_cnt_q;
        stat_mis_cnt_d = stat_mis_cnt_q;
        if (resolve) stat_br_cnt_d = stat_br_cnt_q + 64'd1;
        if (flush_valid_d) stat_mis_cnt_d = stat_mis_cnt_q + 64'd1;
    end

    // Statistics registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            stat_br_cnt_q  <= '0;
            stat_mis_cnt_q <= '0;
        end else begin
            stat_br_cnt_q  <= stat_br_cnt_d;
            stat_mis_cnt_q <= stat_mis_cnt_d;
        end
    end

    assign stat_br_cnt  = stat_br_cnt_q;
    assign stat_mis_cnt = stat_mis_cnt_q;
`endif

endmodule

// File: doc/ysyx_22040759_bru_bp.md
# ysyx_22040759_bru_bp

Branch resolution unit with an integrated branch predictor, replacing the purely combinational branch unit in the EX stage. It resolves JAL/JALR/B-type outcomes, compares them with the prediction that travelled down from IF, and issues a registered one-cycle redirect on mispredict. It also owns a direct-mapped table of 2-bit saturating counters plus targets, which IF reads combinationally to predict the next PC.

## Interface
- XLEN, 64: datapath width.
- BHT_DEPTH, 64: table entries; power of two, ≥2. IDX_W = log2(BHT_DEPTH).
- TAG_W, 8: stored PC tag bits; IDX_W+TAG_W+2 ≤ XLEN.
- clock  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- if_pc  in  XLEN  fetch PC to predict.
- if_pred_taken  out  1  prediction for if_pc.
- if_pred_pc  out  XLEN  predicted next PC.
- ex_valid  in  1  EX holds a valid control-transfer instruction.
- src1, src2  in  XLEN  rs1/rs2 operands.
- bru_sel  in  5  operation: jal/jalr/beq/bne/blt/bge/bltu/bgeu; any other code means no branch.
- bru_wreg_sel  in  2  JAL/JALR count as taken only when this equals wreg_pc.
- imme_b  in  XLEN  sign-extended offset.
- pc_out  in  XLEN  EX instruction PC.
- ex_pred_taken  in  1  prediction carried from IF for pc_out.
- ex_pred_pc  in  XLEN  predicted next PC carried from IF.
- br_taken  out  1  combinational resolved outcome, gated by ex_valid.
- bru_pc  out  XLEN  combinational resolved target.
- flush_valid  out  1  registered redirect request.
- flush_pc  out  XLEN  registered redirect PC.

## Operation
- Compares: equ = src1==src2; lt is the signed compare; ltu is the unsigned compare.
- Target:
  - JALR: (src1+imme_b) & ~1.
  - All others: pc_out+imme_b, modulo 2^XLEN.
- Taken conditions:
  - JAL/JALR: taken if bru_wreg_sel==wreg_pc.
  - beq: equ. bne: !equ. blt: lt. bge: !lt. bltu: ltu. bgeu: !ltu.
- Resolve fires when ex_valid && bru_sel is a branch code && !flush_valid.
- actual_next = taken ? bru_pc : pc_out+4.
- Mispredict = taken != ex_pred_taken, or taken && ex_pred_pc != bru_pc.
- Table entry fields: cnt[1:0], valid, tag, target.
  - idx = pc[IDX_W+1:2]; tag = pc[IDX_W+TAG_W+1:IDX_W+2].
- Lookup (combinational): hit = valid && tag match.
  - if_pred_taken = hit && cnt[1].
  - if_pred_pc = if_pred_taken ? target : if_pc+4.
- Update on resolve:
  - cnt saturates upward when taken and downward when not taken (00..11).
  - If taken, write valid=1, tag and target=bru_pc.
  - If the tag mismatched, first reinitialise cnt to 01 and then apply the step.

## Timing
- br_taken and bru_pc are zero-latency combinational outputs.
- flush_valid/flush_pc are registered from the mispredict decision in cycle N and visible in cycle N+1.
- flush_valid is high for exactly one cycle.
- In a cycle where flush_valid=1, ex_valid is ignored: that is a wrong-path instruction, with no update, no flush and br_taken=0.
- Table writes occur on the clock edge ending the resolve cycle.
- Lookup in the same cycle at the same idx returns the pre-write value (read-before-write).
- Reset:
  - flush_valid=0, flush_pc=0.
  - Every cnt=01, every valid=0.
  - Counters cleared.
- Reset asserted mid-operation overrides any pending update or flush in the same cycle.

## Configuration
- YSYX_22040759_BP_STATS_EN defined:
  - Adds outputs stat_br_cnt (64) = resolves and stat_mis_cnt (64) = mispredicts.
  - Both reset to 0, increment in the resolve cycle and wrap at 2^64.
- Undefined: these ports and registers are absent; all other behaviour is identical.

## Structure
- bru_sel codes (`bru_jal`…`bru_bgeu`) and `wreg_pc` stay in the shared define file.
- Counter reset value 2'b01 is added there as `bp_cnt_init`.
- One sub-module, ysyx_22040759_bp_table, holds the table storage and read/update logic.
- The top level keeps compare/resolve/flush logic.

## Test plan
- After reset, if_pc=0x8000_0000 -> if_pred_taken=0, if_pred_pc=0x8000_0004; flush_valid=0.
- beq, src1=src2=5, pc_out=0x8000_0010, imme_b=0x20, ex_pred_taken=0 -> br_taken=1, bru_pc=0x8000_0030; next cycle flush_valid=1, flush_pc=0x8000_0030 for one cycle; then lookup of 0x8000_0010 -> cnt=10, predicted taken to 0x8000_0030.
- jalr, src1=0x8000_0101, imme_b=0x10, bru_wreg_sel=wreg_pc, ex_pred_pc=0x8000_0110 (correct) -> bru_pc=0x8000_0110, no flush.
- blt, src1=-1, src2=1, plus bltu with the same operands -> blt taken, bltu not taken.
- After a flush, ex_valid=1 with a mispredicting bne in the flush cycle -> ignored: no second flush, and the table entry is unchanged.
- Four taken resolves at one PC, then four not-taken -> cnt goes 01→10→11→11→11, then 10→01→00→00; with YSYX_22040759_BP_STATS_EN, stat_br_cnt=8 afterward.
